// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, and presents each word downstream.
// Memory errors, timeouts and misaligned targets are turned into the bad-trap word 32'h7f.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, valid and its payload hold until that edge (halt is the only retraction).

    localparam int          TMO_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [31:0] BAD_TRAP = 32'h0000_007f;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_nxt;
    logic [31:0]      pc_nxt;
    logic [31:0]      instruction_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             misaligned;

    assign misaligned = (fetch_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        pc_nxt          = pc;
        instruction_nxt = instruction;
        tmo_cnt_nxt     = tmo_cnt;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (misaligned) begin
                    instruction_nxt = BAD_TRAP;
                    pc_nxt          = fetch_pc;
                    state_nxt       = S_OUT;
                end else if (imem_req_ready) begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the final timeout cycle still wins over the fault.
                if (imem_rsp_valid) begin
                    instruction_nxt = imem_rsp_err ? BAD_TRAP : imem_rsp_data;
                    pc_nxt          = fetch_pc;
                    state_nxt       = S_OUT;
                end else if (tmo_cnt == TMO_LAST) begin
                    instruction_nxt = BAD_TRAP;
                    pc_nxt          = fetch_pc;
                    state_nxt       = S_OUT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    if (instruction == EBREAK || instruction == BAD_TRAP) begin
                        state_nxt = S_HALT;
                    end else begin
                        fetch_pc_nxt = redirect_valid ? redirect_pc : pc + 32'd4;
                        state_nxt    = S_REQ;
                    end
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        if (halt) begin
            state_nxt = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            instruction <= '0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            pc          <= pc_nxt;
            instruction <= instruction_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
        end
    end

    assign imem_req_valid = (state == S_REQ) && !misaligned;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == S_OUT);
    assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: straight-line fetch, redirect, wrap, misalignment, faults, halt and reset.
module tb_ifu_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] BAD    = 32'h0000_007f;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        halted;

    // Memory responder: automatic zero-wait model or manual override from the tasks.
    logic        auto_rsp = 1'b1;
    logic        auto_v = 1'b0;
    logic [31:0] auto_data = 32'h0;
    logic        err_cfg = 1'b0;
    logic        force_en = 1'b0;
    logic [31:0] force_data = 32'h0;
    logic        man_v = 1'b0;
    logic [31:0] man_data = 32'h0;
    logic        hs;
    logic [31:0] hs_addr;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc), .instruction(instruction),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    always @(posedge clk) begin
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        #1;
        auto_v    = hs;
        auto_data = force_en ? force_data : mem_word(hs_addr);
    end

    assign imem_rsp_valid = auto_rsp ? auto_v : man_v;
    assign imem_rsp_data  = auto_rsp ? auto_data : man_data;
    assign imem_rsp_err   = auto_rsp ? err_cfg : 1'b0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({imem_req_valid, inst_valid, halted, imem_req_addr, pc, instruction} !== {3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b iv=%b h=%b addr=%h pc=%h ins=%h", imem_req_valid, inst_valid, halted, imem_req_addr, pc, instruction);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("FAIL first_req: got v=%b addr=%h expected 1 80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_straight_redirect();
        step(1);
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_quiet: got req_v=%b inst_v=%b expected 0 0", imem_req_valid, inst_valid);
        end
        step(1);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step(3);
            checks++;
            if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0000 + 32'(4 * i), mem_word(32'h8000_0000 + 32'(4 * i))}) begin
                errors++;
                $display("FAIL seq_%0d: got iv=%b pc=%h ins=%h", i, inst_valid, pc, instruction);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step(1);
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
            errors++;
            $display("FAIL redirect_addr: got v=%b addr=%h expected 1 80000100", imem_req_valid, imem_req_addr);
        end
        redirect_pc = 32'hFFFF_FFFC;
        step(2);
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0100, 32'h1000_0013}) begin
            errors++;
            $display("FAIL redirect_out: got iv=%b pc=%h ins=%h expected 1 80000100 10000013", inst_valid, pc, instruction);
        end
        step(1);
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: got addr=%h expected fffffffc", imem_req_addr);
        end
        step(3);
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_addr: got v=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step(1);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_noreq: got req_v=%b expected 0", imem_req_valid);
        end
        step(1);
        redirect_valid = 1'b0;
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0102, BAD}) begin
            errors++;
            $display("FAIL misaligned_out: got iv=%b pc=%h ins=%h expected 1 80000102 0000007f", inst_valid, pc, instruction);
        end
        step(1);
        checks++;
        if ({halted, inst_valid, imem_req_valid} !== 3'b100) begin
            errors++;
            $display("FAIL misaligned_halt: got h=%b iv=%b rv=%b expected 1 0 0", halted, inst_valid, imem_req_valid);
        end
    endtask

    task automatic test_error();
        err_cfg = 1'b1;
        do_reset();
        step(2);
        err_cfg = 1'b0;
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0000, BAD}) begin
            errors++;
            $display("FAIL rsp_err: got iv=%b pc=%h ins=%h expected 1 80000000 0000007f", inst_valid, pc, instruction);
        end
        step(1);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL err_halt: got halted=%b expected 1", halted);
        end
    endtask

    task automatic test_timeout();
        auto_rsp = 1'b0;
        do_reset();
        step(4);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got iv=%b expected 0 in 4th wait cycle", inst_valid);
        end
        step(1);
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0000, BAD}) begin
            errors++;
            $display("FAIL timeout_fault: got iv=%b pc=%h ins=%h expected 1 80000000 0000007f", inst_valid, pc, instruction);
        end
    endtask

    task automatic test_rsp_on_timeout();
        auto_rsp = 1'b0;
        do_reset();
        step(4);
        man_v    = 1'b1;
        man_data = 32'h1234_5013;
        step(1);
        man_v = 1'b0;
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0000, 32'h1234_5013}) begin
            errors++;
            $display("FAIL rsp_wins: got iv=%b pc=%h ins=%h expected 1 80000000 12345013", inst_valid, pc, instruction);
        end
        step(1);
        checks++;
        if ({imem_req_valid, imem_req_addr, halted} !== {1'b1, 32'h8000_0004, 1'b0}) begin
            errors++;
            $display("FAIL rsp_wins_next: got v=%b addr=%h h=%b expected 1 80000004 0", imem_req_valid, imem_req_addr, halted);
        end
        auto_rsp = 1'b1;
    endtask

    task automatic test_ebreak_backpressure();
        force_en   = 1'b1;
        force_data = EBREAK;
        inst_ready = 1'b0;
        do_reset();
        step(2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({inst_valid, imem_req_valid, pc, instruction} !== {2'b10, 32'h8000_0000, EBREAK}) begin
                errors++;
                $display("FAIL stall_%0d: got iv=%b rv=%b pc=%h ins=%h", i, inst_valid, imem_req_valid, pc, instruction);
            end
            if (i != 5) step(1);
        end
        inst_ready = 1'b1;
        step(1);
        force_en = 1'b0;
        checks++;
        if ({halted, inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ebreak_halt: got h=%b iv=%b expected 1 0", halted, inst_valid);
        end
        auto_rsp = 1'b0;
        man_v    = 1'b1;
        man_data = 32'h0000_0013;
        step(1);
        man_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({halted, inst_valid, imem_req_valid} !== 3'b100) begin
                errors++;
                $display("FAIL late_rsp_%0d: got h=%b iv=%b rv=%b expected 1 0 0", i, halted, inst_valid, imem_req_valid);
            end
            step(1);
        end
        auto_rsp = 1'b1;
    endtask

    task automatic test_halt();
        imem_req_ready = 1'b0;
        do_reset();
        step(2);
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("FAIL req_stall: got v=%b addr=%h expected 1 80000000", imem_req_valid, imem_req_addr);
        end
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        checks++;
        if ({imem_req_valid, halted} !== 2'b01) begin
            errors++;
            $display("FAIL halt_drop: got rv=%b h=%b expected 0 1", imem_req_valid, halted);
        end
        imem_req_ready = 1'b1;
        step(2);
        checks++;
        if ({imem_req_valid, halted} !== 2'b01) begin
            errors++;
            $display("FAIL halt_sticky: got rv=%b h=%b expected 0 1", imem_req_valid, halted);
        end
    endtask

    task automatic test_reset_in_wait();
        auto_rsp = 1'b0;
        do_reset();
        step(1);
        rst = 1'b1;
        step(1);
        checks++;
        if ({imem_req_valid, inst_valid, halted, pc, imem_req_addr} !== {3'b000, 32'h8000_0000, 32'h8000_0000}) begin
            errors++;
            $display("FAIL reset_in_wait: got rv=%b iv=%b h=%b pc=%h addr=%h", imem_req_valid, inst_valid, halted, pc, imem_req_addr);
        end
        rst      = 1'b0;
        man_v    = 1'b1;
        man_data = 32'hDEAD_0013;
        step(1);
        man_v    = 1'b0;
        auto_rsp = 1'b1;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stale_ignored: got rv=%b iv=%b expected 1 0", imem_req_valid, inst_valid);
        end
        step(2);
        checks++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h8000_0000, 32'h0000_0013}) begin
            errors++;
            $display("FAIL post_reset_fetch: got iv=%b pc=%h ins=%h expected 1 80000000 00000013", inst_valid, pc, instruction);
        end
    endtask

    initial begin
        test_reset();
        test_straight_redirect();
        test_error();
        test_timeout();
        test_rsp_on_timeout();
        test_ebreak_backpressure();
        test_halt();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that produces the `pc` / `instruction` stream consumed by the decode stage and the simulation trap monitor. It owns the program counter and issues one fetch at a time to instruction memory over a valid/ready request and valid response interface. It presents each fetched word downstream under a valid/ready handshake and stops fetching after delivering `ebreak` or a fault. Memory errors, timeouts and misaligned redirects are converted into the reserved bad-trap word `32'h0000007f` (opcode `7'b1111111`), so the trap monitor reports them as BAD TRAP.

## Interface
- `RESET_PC`, default `32'h8000_0000`: first fetch address.
- `TIMEOUT`, default `256`: maximum number of WAIT cycles without a response before a fault is declared; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  fetch address, word aligned.
- `imem_rsp_valid`  in  1  response valid (single-cycle pulse).
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  response carries an access error.
- `inst_valid`  out  1  `pc` / `instruction` valid.
- `inst_ready`  in  1  downstream accepts the instruction.
- `pc`  out  32  address of the presented instruction.
- `instruction`  out  32  presented instruction word.
- `redirect_valid`  in  1  downstream supplies a non-sequential next PC.
- `redirect_pc`  in  32  next PC; sampled only on the instruction handshake.
- `halt`  in  1  stop fetching immediately.
- `halted`  out  1  unit is in HALT.

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT. Internal registers: `fetch_pc`, `tmo_cnt` (width `$clog2(TIMEOUT+1)`).
- While `rst` is high: next state is IDLE, `fetch_pc = RESET_PC`, `pc = RESET_PC`, `instruction = 0`, `tmo_cnt = 0`. All outputs read 0 except `imem_req_addr = RESET_PC` and `pc = RESET_PC`.
- IDLE → REQ unconditionally.
- REQ:
  - `imem_req_valid = 1`, `imem_req_addr = fetch_pc`; both held stable until `imem_req_ready`.
  - If `fetch_pc[1:0] != 0`, no request is issued (`imem_req_valid = 0`). Instead, `instruction <= 32'h7f`, `pc <= fetch_pc`, → OUT.
  - On handshake: → WAIT, `tmo_cnt <= 0`.
- WAIT:
  - On `imem_rsp_valid`: `instruction <= imem_rsp_err ? 32'h7f : imem_rsp_data`, `pc <= fetch_pc`, → OUT.
  - Otherwise `tmo_cnt++`. When `tmo_cnt == TIMEOUT-1` with no response: `instruction <= 32'h7f`, `pc <= fetch_pc`, → OUT.
  - A response arriving on the timeout cycle wins over the timeout.
- OUT:
  - `inst_valid = 1`; `pc` and `instruction` held stable until `inst_ready`.
  - On handshake, if `instruction == 32'h00100073` (ebreak) or `instruction == 32'h7f`: → HALT.
  - Otherwise `fetch_pc <= redirect_valid ? redirect_pc : pc + 4` (modulo 2^32, so `32'hFFFF_FFFC + 4 = 0`), → REQ.
- HALT: terminal until `rst`; `halted = 1`, no requests issued, `inst_valid = 0`.
- `halt` high in any state: → HALT at the next edge; `rst` has priority over `halt`.
  - An outstanding request or response is abandoned.
  - `imem_req_valid` drops immediately, even if not yet accepted. This is the only permitted retraction.
- `imem_rsp_valid` outside WAIT is ignored. This includes late responses after a timeout and responses arriving after reset.
- At most one fetch is outstanding; there is no prefetch.

## Timing
- Request handshake occurs at the earliest 1 cycle after `rst` falls (the IDLE cycle).
- Zero-wait memory (`imem_req_ready = 1`, response on the cycle after the request handshake) with `inst_ready = 1`:
  - cycle t: REQ handshake;
  - t+1: WAIT, response sampled;
  - t+2: `inst_valid`, downstream handshake;
  - t+3: next REQ.
  - Throughput is one instruction per 3 cycles.
- The output registers `pc`, `instruction`, `inst_valid` and `halted` update only on clock edges. `imem_req_valid` and `inst_valid` are decoded from the state register, with no combinational path from inputs, except the `halt`/`rst` effects at the next edge.
- Downstream back-pressure stalls in OUT indefinitely; no timeout applies in OUT.

## Test plan
- **Reset and straight-line fetch.** Reset 3 cycles, zero-wait memory returns `addi` words, `inst_ready = 1`.
  - First `imem_req_addr = 32'h8000_0000` one cycle after `rst` falls.
  - `pc` sequence `80000000`, `80000004`, `80000008`, one every 3 cycles.
- **Redirect and misalignment.**
  - With `redirect_valid = 1`, `redirect_pc = 32'h8000_0100` on the handshake: the next request address is `80000100`.
  - With `redirect_pc = 32'h8000_0102`: no memory request; `instruction = 32'h7f`, `pc = 80000102`; then `halted = 1`.
- **Error and timeout.**
  - `imem_rsp_err = 1`: `instruction = 32'h7f`.
  - With `TIMEOUT = 4` and no response: fault presented on the 4th WAIT cycle.
  - A response on that exact cycle delivers the data, not a fault.
- **Ebreak and back-pressure.**
  - Memory returns `32'h00100073` while `inst_ready = 0` for 5 cycles: `pc` and `instruction` stay stable.
  - After acceptance: HALT, no further requests, late `imem_rsp_valid` ignored.
- **Halt and reset mid-operation.**
  - `halt` asserted while REQ is stalled (`imem_req_ready = 0`): `imem_req_valid` drops at the next edge.
  - `rst` asserted in WAIT: returns to IDLE, and the stale response one cycle later is ignored.
- **PC wrap-around.** `RESET_PC = 32'hFFFF_FFFC`, sequential fetch: the second request address is `32'h0000_0000`.
